hud_text_writer: RTL and testbench

- Sequencer that owns the write port of the HUD text RAM (160 x 8-bit character cells) and keeps its contents current.
- After reset it clears the RAM and writes the static labels.
- On each refresh request it snapshots game state, converts score and timer to decimal with a shared sequential binary-to-BCD unit, and streams the dynamic characters into the RAM.
- It sits between the game-logic/timer blocks and the text RAM feeding the VGA text overlay.

---
 rtl/hud_text_pkg.sv | 40 ++++
 rtl/hud_text_writer_if.sv | 24 ++
 rtl/bin2bcd_seq.sv | 48 ++++
 rtl/hud_text_writer.sv | 167 ++++++++++++++++
 tb/tb_hud_text_writer.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/hud_text_pkg.sv
// hud_text_pkg: FSM states, screen layout and character constants shared by the HUD text writer.
package hud_text_pkg;

    typedef enum logic [2:0] {
        INIT_CLEAR,
        INIT_LABEL,
        IDLE,
        CONV_SCORE,
        CONV_TIMER,
        WRITE,
        FINISH
    } state_t;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] ch;
    } label_t;

    localparam int LABEL_N = 25;
    localparam int DYN_N   = 16;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] SCORE_ADDR  = 8'd7;
    localparam logic [7:0] LIVES_ADDR  = 8'd32;
    localparam logic [7:0] TIMER_ADDR  = 8'd87;
    localparam logic [7:0] STATUS_ADDR = 8'd113;

    localparam logic [0:8][7:0] STATUS_WON  = {"Game", 8'h00, "Won", 8'h00};
    localparam logic [0:8][7:0] STATUS_OVER = {"Game", 8'h00, "Over"};
    localparam logic [0:8][7:0] STATUS_PLAY = {"Play!", 32'h0};

    localparam label_t LABELS [LABEL_N] = '{
        '{8'd0,   "S"}, '{8'd1,   "c"}, '{8'd2,   "o"}, '{8'd3,   "r"}, '{8'd4,   "e"}, '{8'd5,   ":"},
        '{8'd25,  "L"}, '{8'd26,  "i"}, '{8'd27,  "v"}, '{8'd28,  "e"}, '{8'd29,  "s"}, '{8'd30,  ":"},
        '{8'd80,  "T"}, '{8'd81,  "i"}, '{8'd82,  "m"}, '{8'd83,  "e"}, '{8'd84,  "r"}, '{8'd85,  ":"},
        '{8'd105, "S"}, '{8'd106, "t"}, '{8'd107, "a"}, '{8'd108, "t"}, '{8'd109, "u"}, '{8'd110, "s"},
        '{8'd111, ":"}
    };

endpackage

// File: rtl/hud_text_writer_if.sv
// hud_text_writer_if: game-state inputs and text RAM write port of the HUD text writer.
interface hud_text_writer_if;
    logic        refresh;
    logic [9:0]  score;
    logic [31:0] counter;
    logic [7:0]  lives;
    logic        win;
    logic        lose;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    modport master (
        output refresh, score, counter, lives, win, lose,
        input  wr_en, wr_addr, wr_data, busy, done
    );

    modport slave (
        input  refresh, score, counter, lives, win, lose,
        output wr_en, wr_addr, wr_data, busy, done
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 10-bit binary to 4-digit BCD, double-dabble with one shift per cycle.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  bin,
    output logic [15:0] bcd,
    output logic        busy,
    output logic        done
);
    logic [25:0] r_sh;
    logic [25:0] w_adj;
    logic [25:0] w_nx;
    logic [3:0]  r_cnt;

    always_comb begin
        w_adj = r_sh;
        for (int i = 0; i < 4; i++)
            w_adj[10 + 4 * i +: 4] = (r_sh[10 + 4 * i +: 4] > 4'd4) ? r_sh[10 + 4 * i +: 4] + 4'd3 : r_sh[10 + 4 * i +: 4];
    end

    assign w_nx = {w_adj[24:0], 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh  <= '0;
            r_cnt <= '0;
            bcd   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                r_sh  <= {16'd0, bin};
                r_cnt <= 4'd10;
                busy  <= 1'b1;
            end else if (busy) begin
                r_sh  <= w_nx;
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    bcd  <= w_nx[25:10];
                end
            end
        end
    end
endmodule

// File: rtl/hud_text_writer.sv
// hud_text_writer: owns the HUD text RAM write port; clears and labels it after reset,
// then rewrites score, lives, timer and status on each refresh.
module hud_text_writer
    import hud_text_pkg::*;
#(
    parameter int RAM_DEPTH = 160,
    parameter int MAX_LIVES = 3
) (
    input logic              Clk,
    input logic              Reset,
    hud_text_writer_if.slave bus
);
    state_t      r_state;
    logic [7:0]  r_idx;
    logic        r_pending;
    logic [31:0] r_counter;
    logic [7:0]  r_lives;
    logic        r_win;
    logic        r_lose;
    logic [11:0] r_score_bcd;
    logic [11:0] r_timer_bcd;
    logic        r_wr_en;
    logic [7:0]  r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_busy;
    logic        r_done;

    logic            w_go;
    logic            w_bcd_start;
    logic            w_bcd_busy;
    logic            w_bcd_done;
    logic [9:0]      w_bcd_bin;
    logic [9:0]      w_sat;
    logic [15:0]     w_bcd;
    logic            w_unused_thousands;
    logic [3:0]      w_k;
    logic [3:0]      w_sd;
    logic [3:0]      w_td;
    logic [0:8][7:0] w_status;
    logic [7:0]      w_lives_ch;
    logic [7:0]      w_dyn_addr;
    logic [7:0]      w_dyn_data;

    // Score is converted straight off the input on the sampling edge; the timer follows from its snapshot.
    assign w_go        = (bus.refresh || r_pending) && !w_bcd_busy;
    assign w_sat       = (r_counter > 32'd999) ? 10'd999 : r_counter[9:0];
    assign w_bcd_start = (r_state == IDLE && w_go) || (r_state == CONV_SCORE && w_bcd_done);
    assign w_bcd_bin   = (r_state == IDLE) ? bus.score : w_sat;
    assign w_unused_thousands = ^w_bcd[15:12];

    bin2bcd_seq u_bcd (
        .clk   (Clk),
        .rst   (Reset),
        .start (w_bcd_start),
        .bin   (w_bcd_bin),
        .bcd   (w_bcd),
        .busy  (w_bcd_busy),
        .done  (w_bcd_done)
    );

    assign w_k        = r_idx[3:0] - 4'd7;
    assign w_status   = r_win ? STATUS_WON : (r_lose ? STATUS_OVER : STATUS_PLAY);
    assign w_sd       = (r_idx == 8'd0) ? r_score_bcd[11:8] : (r_idx == 8'd1) ? r_score_bcd[7:4] : r_score_bcd[3:0];
    assign w_td       = (r_idx == 8'd4) ? r_timer_bcd[11:8] : (r_idx == 8'd5) ? r_timer_bcd[7:4] : r_timer_bcd[3:0];
    assign w_lives_ch = (r_lives >= 8'(MAX_LIVES)) ? ASCII_ZERO : ASCII_ZERO + 8'(MAX_LIVES) - r_lives;

    always_comb begin
        w_dyn_addr = STATUS_ADDR + {4'd0, w_k};
        w_dyn_data = w_status[w_k];
        if (r_idx < 8'd3) begin
            w_dyn_addr = SCORE_ADDR + r_idx;
            w_dyn_data = ASCII_ZERO + {4'd0, w_sd};
        end else if (r_idx == 8'd3) begin
            w_dyn_addr = LIVES_ADDR;
            w_dyn_data = w_lives_ch;
        end else if (r_idx < 8'd7) begin
            w_dyn_addr = TIMER_ADDR + r_idx - 8'd4;
            w_dyn_data = ASCII_ZERO + {4'd0, w_td};
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= INIT_CLEAR;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            r_counter   <= '0;
            r_lives     <= '0;
            r_win       <= 1'b0;
            r_lose      <= 1'b0;
            r_score_bcd <= '0;
            r_timer_bcd <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done  <= 1'b0;
            if (bus.refresh && r_state != IDLE)
                r_pending <= 1'b1;
            case (r_state)
                INIT_CLEAR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_idx;
                    r_wr_data <= 8'h00;
                    r_idx     <= (r_idx == 8'(RAM_DEPTH - 1)) ? 8'd0 : r_idx + 8'd1;
                    if (r_idx == 8'(RAM_DEPTH - 1))
                        r_state <= INIT_LABEL;
                end
                INIT_LABEL: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= LABELS[r_idx[4:0]].addr;
                    r_wr_data <= LABELS[r_idx[4:0]].ch;
                    r_idx     <= (r_idx == 8'(LABEL_N - 1)) ? 8'd0 : r_idx + 8'd1;
                    if (r_idx == 8'(LABEL_N - 1))
                        r_state <= FINISH;
                end
                IDLE: begin
                    if (w_go) begin
                        r_counter <= bus.counter;
                        r_lives   <= bus.lives;
                        r_win     <= bus.win;
                        r_lose    <= bus.lose;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= CONV_SCORE;
                    end
                end
                CONV_SCORE: begin
                    if (w_bcd_done) begin
                        r_score_bcd <= w_bcd[11:0];
                        r_state     <= CONV_TIMER;
                    end
                end
                CONV_TIMER: begin
                    if (w_bcd_done) begin
                        r_timer_bcd <= w_bcd[11:0];
                        r_idx       <= 8'd0;
                        r_state     <= WRITE;
                    end
                end
                WRITE: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= w_dyn_addr;
                    r_wr_data <= w_dyn_data;
                    r_idx     <= (r_idx == 8'(DYN_N - 1)) ? 8'd0 : r_idx + 8'd1;
                    if (r_idx == 8'(DYN_N - 1))
                        r_state <= FINISH;
                end
                FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= INIT_CLEAR;
            endcase
        end
    end

    assign bus.wr_en   = r_wr_en;
    assign bus.wr_addr = r_wr_addr;
    assign bus.wr_data = r_wr_data;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
endmodule

// File: tb/tb_hud_text_writer.sv
// tb_hud_text_writer: directed checks of init, update passes, refresh collapsing and async reset.
module tb_hud_text_writer;
    typedef logic [0:15][7:0] pass_t;

    localparam pass_t DYN_ADDR = {8'd7, 8'd8, 8'd9, 8'd32, 8'd87, 8'd88, 8'd89,
                                  8'd113, 8'd114, 8'd115, 8'd116, 8'd117, 8'd118, 8'd119, 8'd120, 8'd121};

    logic Clk;
    logic Reset;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nw = 0;
    int   done_cnt = 0;
    int   done_cyc = 0;
    logic [7:0] la [1024];
    logic [7:0] ld [1024];
    int         lc [1024];

    hud_text_writer_if bus ();

    hud_text_writer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Mirrors the RAM: a write is whatever wr_en/addr/data hold during the cycle.
    always @(negedge Clk) begin
        if (bus.wr_en && nw < 1024) begin
            la[nw] = bus.wr_addr;
            ld[nw] = bus.wr_data;
            lc[nw] = cyc;
            nw++;
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic set_in(input int s, input int c, input int l, input logic w, input logic f);
        bus.score   = 10'(s);
        bus.counter = 32'(c);
        bus.lives   = 8'(l);
        bus.win     = w;
        bus.lose    = f;
    endtask

    task automatic pulse();
        bus.refresh = 1'b1;
        tick(1);
        bus.refresh = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int n, input int limit);
        for (int i = 0; i < limit && done_cnt < n; i++)
            tick(1);
        chk({tag, " timeout"}, 32'(done_cnt >= n), 1);
    endtask

    task automatic check_pass(input string tag, input int base, input pass_t exp);
        int gaps = 0;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("%s w%0d", tag, i), {16'd0, la[base + i], ld[base + i]}, {16'd0, DYN_ADDR[i], exp[i]});
            if (i > 0 && lc[base + i] != lc[base + i - 1] + 1)
                gaps++;
        end
        chk({tag, " gaps"}, 32'(gaps), 0);
    endtask

    initial begin
        string lbl [4] = '{"Score:", "Lives:", "Timer:", "Status:"};
        int    lbase [4] = '{0, 25, 80, 105};
        int    m;
        int    d;
        int    r;
        int    k;
        int    errs;

        Reset = 1'b1;
        bus.refresh = 1'b0;
        set_in(0, 0, 0, 1'b0, 1'b0);
        tick(2);
        chk("rst wr_en", 32'(bus.wr_en), 0);
        chk("rst wr_addr", 32'(bus.wr_addr), 0);
        chk("rst wr_data", 32'(bus.wr_data), 0);
        chk("rst done", 32'(bus.done), 0);
        chk("rst busy", 32'(bus.busy), 1);

        m = nw;
        d = done_cnt;
        Reset = 1'b0;
        wait_done("init", d + 1, 400);
        chk("init count", 32'(nw - m), 185);
        errs = 0;
        for (int i = 0; i < 160; i++)
            if (la[m + i] != 8'(i) || ld[m + i] != 8'h00 || (i > 0 && lc[m + i] != lc[m + i - 1] + 1))
                errs++;
        chk("init clear", 32'(errs), 0);
        errs = 0;
        k = m + 160;
        for (int j = 0; j < 4; j++)
            for (int c = 0; c < lbl[j].len(); c++) begin
                if (la[k] != 8'(lbase[j] + c) || ld[k] != lbl[j].getc(c) || lc[k] != lc[k - 1] + 1)
                    errs++;
                k++;
            end
        chk("init labels", 32'(errs), 0);
        chk("label first", {16'd0, la[m + 160], ld[m + 160]}, {16'd0, 8'd0, 8'h53});
        chk("label last", {16'd0, la[m + 184], ld[m + 184]}, {16'd0, 8'd111, 8'h3A});
        chk("init done timing", 32'(done_cyc), 32'(lc[m + 184] + 1));
        chk("init done once", 32'(done_cnt - d), 1);
        chk("init busy", 32'(bus.busy), 0);

        set_in(427, 58, 1, 1'b0, 1'b0);
        m = nw;
        d = done_cnt;
        r = cyc + 1;
        pulse();
        set_in(0, 0, 0, 1'b1, 1'b1);
        wait_done("p1", d + 1, 100);
        chk("p1 count", 32'(nw - m), 16);
        check_pass("p1", m, {8'h34, 8'h32, 8'h37, 8'h32, 8'h30, 8'h35, 8'h38, "Play!", 32'h0});
        chk("p1 first lat", 32'(lc[m] - r <= 24), 1);
        chk("p1 total lat", 32'(done_cyc - r <= 42), 1);
        chk("p1 done timing", 32'(done_cyc), 32'(lc[m + 15] + 1));
        chk("p1 done once", 32'(done_cnt - d), 1);
        chk("p1 busy", 32'(bus.busy), 0);

        set_in(1023, 5000, 5, 1'b1, 1'b1);
        m = nw;
        d = done_cnt;
        pulse();
        wait_done("p2", d + 1, 100);
        chk("p2 count", 32'(nw - m), 16);
        check_pass("p2", m, {8'h30, 8'h32, 8'h33, 8'h30, 8'h39, 8'h39, 8'h39, "Game", 8'h00, "Won", 8'h00});

        set_in(0, 1000, 0, 1'b0, 1'b1);
        m = nw;
        d = done_cnt;
        pulse();
        wait_done("p3", d + 1, 100);
        chk("p3 count", 32'(nw - m), 16);
        check_pass("p3", m, {8'h30, 8'h30, 8'h30, 8'h33, 8'h39, 8'h39, 8'h39, "Game", 8'h00, 8'h4F, 8'h76, 8'h65, 8'h72});

        set_in(999, 999, 3, 1'b0, 1'b0);
        m = nw;
        d = done_cnt;
        pulse();
        for (int i = 0; i < 60 && nw - m < 2; i++)
            tick(1);
        set_in(5, 12, 2, 1'b1, 1'b0);
        pulse();
        tick(1);
        pulse();
        tick(1);
        pulse();
        wait_done("p45", d + 2, 150);
        tick(60);
        chk("p45 count", 32'(nw - m), 32);
        chk("p45 done count", 32'(done_cnt - d), 2);
        check_pass("p4", m, {8'h39, 8'h39, 8'h39, 8'h30, 8'h39, 8'h39, 8'h39, "Play!", 32'h0});
        check_pass("p5", m + 16, {8'h30, 8'h30, 8'h35, 8'h31, 8'h30, 8'h31, 8'h32, "Game", 8'h00, "Won", 8'h00});
        chk("p5 restart lat", 32'(lc[m + 16] - (lc[m + 15] + 1) <= 25), 1);

        set_in(1, 2, 0, 1'b0, 1'b0);
        m = nw;
        pulse();
        for (int i = 0; i < 60 && nw - m < 3; i++)
            tick(1);
        chk("pre-reset wr_en", 32'(bus.wr_en), 1);
        #2;
        Reset = 1'b1;
        #1;
        chk("async wr_en", 32'(bus.wr_en), 0);
        chk("async wr_addr", 32'(bus.wr_addr), 0);
        chk("async busy", 32'(bus.busy), 1);
        tick(2);
        m = nw;
        d = done_cnt;
        Reset = 1'b0;
        wait_done("reinit", d + 1, 400);
        chk("reinit count", 32'(nw - m), 185);
        chk("reinit first", {16'd0, la[m], ld[m]}, 32'd0);
        chk("reinit last clear", {16'd0, la[m + 159], ld[m + 159]}, {16'd0, 8'd159, 8'h00});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
